// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned SUB_WIDTH_DFLT = 4;

endpackage : serial_subtractor_pkg

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial
// subtractor. The carry flop is held by the parent.
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  // Sum and majority carry of the three input bits
  always_comb begin
    o_sum  = i_a ^ i_b ^ i_cin;
    o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
  end

endmodule : serial_fa_cell

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, computed
// as a + ~b + 1 through one full-adder cell and a carry flop.
// Handshake: start (accepted in IDLE) -> busy for WIDTH+1 cycles -> done pulse.
// Optional macro SERIAL_SUBTRACTOR_FLAGS_EN adds registered zero/lt outputs.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int unsigned WIDTH = SUB_WIDTH_DFLT,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             overflow
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  ,
  output logic             zero,
  output logic             lt
`endif
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  // Only WIDTH-1 result bits need storing; the last bit comes straight
  // from the adder on the final edge.
  logic [WIDTH-2:0]   r_diff_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_sa;
  logic               r_sb;
  logic               w_sum;
  logic               w_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_diff_nxt;
  logic               w_ovf;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic               r_nz;
`endif

  serial_fa_cell u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Final-bit detection, assembled result and signed overflow
  always_comb begin
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    w_diff_nxt = {w_sum, r_diff_sr};
    w_ovf      = (r_sa != r_sb) && (w_sum != r_sa);
  end

  // Busy whenever an operation is in flight or reporting
  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:              w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, serial add/shift and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_diff_sr <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      r_nz      <= 1'b0;
      zero      <= 1'b0;
      lt        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= ~b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_sa    <= a[WIDTH-1];
            r_sb    <= b[WIDTH-1];
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            r_nz    <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          r_carry   <= w_cout;
          r_diff_sr <= w_diff_nxt[WIDTH-1:1];
          r_a_sr    <= r_a_sr >> 1;
          r_b_sr    <= r_b_sr >> 1;
          r_cnt     <= r_cnt + CNT_W'(1);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
          r_nz      <= r_nz | w_sum;
`endif
          if (w_last) begin
            diff      <= w_diff_nxt;
            borrowout <= ~w_cout;
            overflow  <= w_ovf;
            done      <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            zero      <= ~(r_nz | w_sum);
            lt        <= w_sum ^ w_ovf;
`endif
          end
        end
        ST_DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4).
// Flag outputs are checked when SERIAL_SUBTRACTOR_FLAGS_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrowout;
  logic         overflow;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic         zero;
  logic         lt;
`endif

  int n_pass;
  int n_total;

  logic [W-1:0] p_diff;
  logic         p_borrow;
  logic         p_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrowout (borrowout),
    .overflow  (overflow)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    ,
    .zero      (zero),
    .lt        (lt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One operation: checks latency, busy/done shape, hold-until-done and results
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    a = ta; b = tb_; start = 1'b1;
    tick();                      // accepting edge k
    start = 1'b0;
    a = ~ta; b = ta ^ tb_;       // operands may change after acceptance
    chk({tag, "_hold_diff"}, 32'(diff), 32'(p_diff));
    chk({tag, "_hold_flags"}, 32'({borrowout, overflow}), 32'({p_borrow, p_ovf}));
    for (int j = 0; j < int'(W); j++) begin
      chk({tag, "_shift_busydone"}, 32'({busy, done}), 32'(2'b10));
      tick();
    end
    chk({tag, "_done_busydone"}, 32'({busy, done}), 32'(2'b11));
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrowout), 32'(eb));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    chk({tag, "_zero"}, 32'(zero), 32'(ed == '0));
    chk({tag, "_lt"}, 32'(lt), 32'($signed(ta) < $signed(tb_)));
`endif
    tick();
    chk({tag, "_idle_busydone"}, 32'({busy, done}), 32'(2'b00));
    chk({tag, "_idle_diff"}, 32'(diff), 32'(ed));
    p_diff = ed; p_borrow = eb; p_ovf = eo;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    p_diff = '0; p_borrow = 1'b0; p_ovf = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_busydone", 32'({busy, done}), 32'(2'b00));
    chk("reset_outs", 32'({diff, borrowout, overflow}), 32'(0));
    tick();
    chk("idle_no_start", 32'(busy), 32'(0));

    do_op("t1_5m3", 4'd5, 4'd3, 4'b0010, 1'b0, 1'b0);
    do_op("t2_3m5", 4'd3, 4'd5, 4'b1110, 1'b1, 1'b0);
    do_op("t3_7mm1", 4'd7, 4'b1111, 4'b1000, 1'b1, 1'b1);
    do_op("t3_m8m1", 4'b1000, 4'd1, 4'b0111, 1'b0, 1'b1);
    do_op("t4_4m4", 4'd4, 4'd4, 4'b0000, 1'b0, 1'b0);

    // Start while busy is ignored; operand changes mid-SHIFT have no effect
    a = 4'd6; b = 4'd2; start = 1'b1;
    tick();                      // edge k
    start = 1'b0;
    tick();                      // edge k+1
    a = 4'd1; b = 4'd1; start = 1'b1;
    tick();                      // edge k+2, start ignored
    start = 1'b0;
    a = 4'd15; b = 4'd9;
    chk("t5_busy_mid", 32'({busy, done}), 32'(2'b10));
    tick();                      // edge k+3
    chk("t5_not_done_yet", 32'(done), 32'(0));
    tick();                      // edge k+4
    chk("t5_done", 32'({busy, done}), 32'(2'b11));
    chk("t5_diff", 32'({diff, borrowout, overflow}), 32'({4'b0100, 1'b0, 1'b0}));
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("t5_no_second_done", 32'(done), 32'(0));
    end
    chk("t5_diff_held", 32'(diff), 32'(4'b0100));

    // Reset during the second SHIFT cycle discards the operation
    a = 4'd3; b = 4'd5; start = 1'b1;
    tick();                      // edge k
    start = 1'b0;
    tick();                      // edge k+1, now in second SHIFT cycle
    rst_n = 1'b0;
    tick();                      // edge k+2 resets
    rst_n = 1'b1;
    chk("t6_rst_busydone", 32'({busy, done}), 32'(2'b00));
    chk("t6_rst_outs", 32'({diff, borrowout, overflow}), 32'(0));
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    chk("t6_rst_flags", 32'({zero, lt}), 32'(0));
`endif
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t6_no_done", 32'({busy, done}), 32'(2'b00));
    end
    p_diff = '0; p_borrow = 1'b0; p_ovf = 1'b0;
    do_op("t6_fresh", 4'd5, 4'd3, 4'b0010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_serial_subtractor
